// File: rtl/i2s_tdm_transceiver.sv
// rtl/i2s_tdm_transceiver.sv - I2S/TDM master: shared sclk/ws timing, double-buffered serialiser, framed deserialiser
module i2s_tdm_transceiver #(
    parameter int mclk_sclk_ratio = 4,
    parameter int slot_width      = 32,
    parameter int d_width         = 24,
    parameter int channels        = 2,
    parameter int mode            = 0
) (
    input  logic                         mclk,
    input  logic                         reset_n,
    output logic                         sclk,
    output logic                         ws,
    output logic                         sd_tx,
    input  logic                         sd_rx,
    input  logic [channels*d_width-1:0]  tx_data,
    input  logic                         tx_load,
    output logic                         tx_ready,
    output logic                         tx_underrun,
    output logic [channels*d_width-1:0]  rx_data,
    output logic                         rx_valid
);

    localparam int half_ratio = mclk_sclk_ratio / 2;
    localparam int div_w      = (half_ratio > 1) ? $clog2(half_ratio) : 1;
    localparam int sb_w       = $clog2(slot_width);
    localparam int sbx_w      = sb_w + 1;
    localparam int ch_w       = $clog2(channels);
    localparam int frame_w    = channels * d_width;
    localparam int lead       = (mode == 0) ? 1 : 0;

    localparam logic [div_w-1:0] div_last   = div_w'(half_ratio - 1);
    localparam logic [sb_w-1:0]  slot_last  = sb_w'(slot_width - 1);
    localparam logic [ch_w-1:0]  ch_last    = ch_w'(channels - 1);
    localparam logic [ch_w-1:0]  ch_half    = ch_w'(channels / 2);
    localparam logic [sbx_w-1:0] data_first = sbx_w'(lead);
    localparam logic [sbx_w-1:0] data_len   = sbx_w'(d_width);

    logic [div_w-1:0]   div_cnt;
    logic [sb_w-1:0]    slot_bit;
    logic [ch_w-1:0]    slot_idx;
    logic [frame_w-1:0] shadow;
    logic [frame_w-1:0] tx_frame;
    logic               shadow_full;
    logic [d_width-1:0] rx_slot [channels];

    logic               sclk_toggle;
    logic               sclk_fall;
    logic               sclk_rise;
    logic               frame_end;
    logic [sb_w-1:0]    nxt_slot_bit;
    logic [ch_w-1:0]    nxt_slot_idx;
    logic [frame_w-1:0] next_frame;
    logic [d_width-1:0] tx_sample;
    logic [d_width-1:0] tx_shifted;
    logic [sbx_w-1:0]   nxt_data_pos;
    logic [sbx_w-1:0]   cur_data_pos;
    logic               nxt_in_data;
    logic               cur_in_data;

    assign tx_ready = ~shadow_full;

    always_comb begin
        sclk_toggle  = (div_cnt == div_last);
        sclk_fall    = sclk_toggle && sclk;
        sclk_rise    = sclk_toggle && !sclk;
        frame_end    = sclk_fall && (slot_bit == slot_last) && (slot_idx == ch_last);

        nxt_slot_bit = slot_bit + 1'b1;
        nxt_slot_idx = slot_idx;
        if (slot_bit == slot_last) begin
            nxt_slot_bit = '0;
            nxt_slot_idx = (slot_idx == ch_last) ? '0 : slot_idx + 1'b1;
        end

        // The boundary bit must already come from the incoming frame (left-justified MSB sits at offset 0).
        next_frame = (frame_end && shadow_full) ? shadow : tx_frame;

        tx_sample = '0;
        for (int k = 0; k < channels; k++) begin
            if (nxt_slot_idx == ch_w'(k)) begin
                tx_sample = next_frame[k*d_width +: d_width];
            end
        end

        // Offsets before the data window wrap to large values, so one compare bounds both ends.
        nxt_data_pos = {1'b0, nxt_slot_bit} - data_first;
        cur_data_pos = {1'b0, slot_bit} - data_first;
        nxt_in_data  = (nxt_data_pos < data_len);
        cur_in_data  = (cur_data_pos < data_len);
        tx_shifted   = tx_sample << nxt_data_pos;
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            sclk        <= 1'b0;
            ws          <= 1'b0;
            sd_tx       <= 1'b0;
            slot_bit    <= '0;
            slot_idx    <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            tx_frame    <= '0;
            tx_underrun <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            for (int k = 0; k < channels; k++) begin
                rx_slot[k] <= '0;
            end
        end else begin
            tx_underrun <= 1'b0;
            rx_valid    <= 1'b0;
            div_cnt     <= sclk_toggle ? '0 : div_cnt + 1'b1;

            if (sclk_toggle) begin
                sclk <= ~sclk;
            end

            if (sclk_fall) begin
                slot_bit <= nxt_slot_bit;
                slot_idx <= nxt_slot_idx;
                ws       <= (nxt_slot_idx >= ch_half);
                sd_tx    <= nxt_in_data & tx_shifted[d_width-1];
            end

            if (sclk_rise && cur_in_data) begin
                rx_slot[slot_idx] <= {rx_slot[slot_idx][d_width-2:0], sd_rx};
            end

            if (frame_end) begin
                tx_frame    <= next_frame;
                tx_underrun <= ~shadow_full;
                rx_valid    <= 1'b1;
                for (int k = 0; k < channels; k++) begin
                    rx_data[k*d_width +: d_width] <= rx_slot[k];
                end
            end

            // A load landing on an empty-shadow boundary is kept for the following frame.
            if (frame_end && shadow_full) begin
                shadow_full <= 1'b0;
            end else if (tx_load && !shadow_full) begin
                shadow      <= tx_data;
                shadow_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_transceiver.sv
// tb/tb_i2s_tdm_transceiver.sv - scoreboard bench: 2ch I2S and 4ch left-justified builds in loopback
module tb_i2s_tdm_transceiver;

    logic mclk;
    int   cyc = 0;

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) cyc <= cyc + 1;

    logic        rstn0, sclk0, ws0, sd_tx0, tx_load0, tx_ready0, tx_underrun0, rx_valid0;
    logic [47:0] tx_data0, rx_data0;
    logic        rstn1, sclk1, ws1, sd_tx1, tx_load1, tx_ready1, tx_underrun1, rx_valid1;
    logic [95:0] tx_data1, rx_data1;

    i2s_tdm_transceiver u_i2s (
        .mclk(mclk), .reset_n(rstn0), .sclk(sclk0), .ws(ws0), .sd_tx(sd_tx0), .sd_rx(sd_tx0),
        .tx_data(tx_data0), .tx_load(tx_load0), .tx_ready(tx_ready0), .tx_underrun(tx_underrun0),
        .rx_data(rx_data0), .rx_valid(rx_valid0)
    );

    i2s_tdm_transceiver #(.channels(4), .mode(1)) u_tdm (
        .mclk(mclk), .reset_n(rstn1), .sclk(sclk1), .ws(ws1), .sd_tx(sd_tx1), .sd_rx(sd_tx1),
        .tx_data(tx_data1), .tx_load(tx_load1), .tx_ready(tx_ready1), .tx_underrun(tx_underrun1),
        .rx_data(rx_data1), .rx_valid(rx_valid1)
    );

    logic [1:0]   rstn_v, sclk_v, ws_v, sd_tx_v, und_v, rxv_v;
    logic [191:0] rx_data_v [2];
    assign rstn_v       = {rstn1, rstn0};
    assign sclk_v       = {sclk1, sclk0};
    assign ws_v         = {ws1, ws0};
    assign sd_tx_v      = {sd_tx1, sd_tx0};
    assign und_v        = {tx_underrun1, tx_underrun0};
    assign rxv_v        = {rx_valid1, rx_valid0};
    assign rx_data_v[0] = {144'b0, rx_data0};
    assign rx_data_v[1] = {96'b0, rx_data1};

    int n_checks = 0;
    int n_fail   = 0;

    logic [191:0] exp_rx [$];
    logic [191:0] exp_tx [$];

    int           nch_c [2] = '{2, 4};
    int           lead_c [2] = '{1, 0};
    int           pos [2], last_fall [2], rx_cnt [2], und_cnt [2], rx_cyc [2];
    bit           started [2], sclk_p [2], ws_p [2];
    logic [255:0] bits [2];
    logic [191:0] mon_fr;
    int           mon_pad, mon_idx;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic decode(input logic [255:0] b, input int nch, input int lead,
                          output logic [191:0] fr, output int pad);
        int i;
        int idx;
        fr  = '0;
        pad = 0;
        for (int k = 0; k < nch; k++) begin
            for (int p = 0; p < 32; p++) begin
                i   = p - lead;
                idx = k * 32 + p;
                if (i >= 0 && i < 24) begin
                    idx = k * 24 + 23 - i;
                    fr[idx[7:0]] = b[k*32+p];
                end else if (b[idx[7:0]]) begin
                    pad++;
                end
            end
        end
    endtask

    // Monitor: pops expected rx frames on rx_valid, rebuilds tx frames from the pins.
    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_cnt[d] = 0; und_cnt[d] = 0; rx_cyc[d] = 0; last_fall[d] = -1; pos[d] = 0;
        end
        forever begin
            @(negedge mclk);
            for (int d = 0; d < 2; d++) begin
                if (!rstn_v[d]) begin
                    started[d] = 0; sclk_p[d] = 0; ws_p[d] = 0; last_fall[d] = -1; pos[d] = 0;
                end else begin
                    if (rxv_v[d]) begin
                        rx_cnt[d]++;
                        rx_cyc[d] = cyc;
                        if (exp_rx.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL rx_unexpected: dut%0d rx_data %0h, none expected", d, rx_data_v[d]);
                        end else begin
                            check($sformatf("rx_frame_dut%0d", d), rx_data_v[d], exp_rx.pop_front());
                        end
                    end
                    if (und_v[d]) und_cnt[d]++;
                    if (sclk_v[d] && !sclk_p[d]) begin
                        if (!ws_v[d] && ws_p[d]) begin
                            if (started[d]) begin
                                decode(bits[d], nch_c[d], lead_c[d], mon_fr, mon_pad);
                                if (exp_tx.size() == 0) begin
                                    n_checks++; n_fail++;
                                    $display("FAIL tx_unexpected: dut%0d sent %0h, none expected", d, mon_fr);
                                end else begin
                                    check($sformatf("tx_frame_dut%0d", d), mon_fr, exp_tx.pop_front());
                                end
                                check($sformatf("tx_pad_zero_dut%0d", d), 192'(mon_pad), 192'(0));
                            end
                            if (last_fall[d] >= 0)
                                check($sformatf("ws_period_dut%0d", d), 192'(cyc - last_fall[d]), 192'(nch_c[d] * 128));
                            last_fall[d] = cyc;
                            started[d]   = 1;
                            pos[d]       = 0;
                            bits[d]      = '0;
                        end
                        if (ws_v[d] && !ws_p[d] && started[d])
                            check($sformatf("ws_rise_bit_dut%0d", d), 192'(pos[d]), 192'(nch_c[d] * 16));
                        if (started[d] && pos[d] < 256) begin
                            mon_idx = pos[d];
                            bits[d][mon_idx[7:0]] = sd_tx_v[d];
                            pos[d]++;
                        end
                        ws_p[d] = ws_v[d];
                    end
                    sclk_p[d] = sclk_v[d];
                end
            end
        end
    end

    task automatic wait_rx(input int d, input int n, input int budget);
        int t = 0;
        while (rx_cnt[d] < n && t < budget) begin
            @(negedge mclk);
            t++;
        end
        check($sformatf("rx_count_dut%0d", d), 192'(rx_cnt[d]), 192'(n));
    endtask

    task automatic reset_checks0(input string tag);
        check({tag, "_sclk"},        192'(sclk0),        192'(0));
        check({tag, "_ws"},          192'(ws0),          192'(0));
        check({tag, "_sd_tx"},       192'(sd_tx0),       192'(0));
        check({tag, "_tx_ready"},    192'(tx_ready0),    192'(1));
        check({tag, "_tx_underrun"}, 192'(tx_underrun0), 192'(0));
        check({tag, "_rx_valid"},    192'(rx_valid0),    192'(0));
        check({tag, "_rx_data"},     192'(rx_data0),     192'(0));
    endtask

    logic [191:0] fa, fb, fc, fd;
    int c0, c1, r0, u0, t;

    initial begin
        fa = {144'b0, 24'h123456, 24'hABCDEF};
        fb = {144'b0, 24'h0F0F0F, 24'hF0F0F0};
        fc = {96'b0, 24'h000004, 24'h000003, 24'h000002, 24'h000001};
        fd = {96'b0, 24'h7FFFFF, 24'h800000, 24'h5A5A5A, 24'hC00001};
        rstn0 = 0; rstn1 = 0; tx_load0 = 0; tx_load1 = 0; tx_data0 = '0; tx_data1 = '0;

        repeat (10) @(posedge mclk);
        #1 reset_checks0("init");

        @(negedge mclk); rstn0 = 1; c0 = cyc;
        @(posedge mclk); #1 check("sclk_cycle1", 192'(sclk0), 192'(0));
        @(posedge mclk); #1 check("sclk_cycle2", 192'(sclk0), 192'(1));
        exp_rx.push_back('0); exp_rx.push_back(fa); exp_rx.push_back(fa);
        exp_tx.push_back(fa); exp_tx.push_back(fa);
        @(negedge mclk); check("tx_ready_idle", 192'(tx_ready0), 192'(1));
        tx_data0 = fa[47:0]; tx_load0 = 1;
        @(negedge mclk); check("tx_ready_full", 192'(tx_ready0), 192'(0));
        tx_data0 = 48'hDEADBEEF0BAD;
        @(negedge mclk); tx_load0 = 0; tx_data0 = '0;
        wait_rx(0, 1, 400);
        check("rx_latency_i2s", 192'(rx_cyc[0] - c0), 192'(256));
        wait_rx(0, 3, 600);
        repeat (8) @(negedge mclk);
        check("underrun_count_i2s", 192'(und_cnt[0]), 192'(2));
        check("rx_queue_drained_a", 192'(exp_rx.size()), 192'(0));
        check("tx_queue_drained_a", 192'(exp_tx.size()), 192'(0));

        @(negedge mclk); check("tx_ready_before_reset", 192'(tx_ready0), 192'(1));
        tx_data0 = fb[47:0]; tx_load0 = 1;
        @(negedge mclk); tx_load0 = 0;
        t = 0;
        while (pos[0] < 40 && t < 600) begin
            @(negedge mclk);
            t++;
        end
        check("reached_bit40", 192'(pos[0] >= 40), 192'(1));
        rstn0 = 0;
        @(posedge mclk); #1 reset_checks0("midframe");
        repeat (3) @(negedge mclk);
        rstn0 = 1; c0 = cyc; r0 = rx_cnt[0]; u0 = und_cnt[0];
        repeat (250) @(negedge mclk);
        check("no_rx_before_full_frame", 192'(rx_cnt[0]), 192'(r0));
        exp_rx.push_back('0);
        wait_rx(0, r0 + 1, 100);
        check("rx_latency_after_reset", 192'(rx_cyc[0] - c0), 192'(256));
        check("underrun_after_reset", 192'(und_cnt[0]), 192'(u0 + 1));
        @(negedge mclk); rstn0 = 0;

        @(negedge mclk); rstn1 = 1; c1 = cyc;
        exp_rx.push_back('0); exp_rx.push_back(fc); exp_rx.push_back(fc); exp_rx.push_back(fd);
        exp_tx.push_back(fc); exp_tx.push_back(fc); exp_tx.push_back(fd);
        @(negedge mclk); check("tx_ready_idle_tdm", 192'(tx_ready1), 192'(1));
        tx_data1 = fc[95:0]; tx_load1 = 1;
        @(negedge mclk); tx_load1 = 0;
        wait_rx(1, 1, 700);
        check("rx_latency_tdm", 192'(rx_cyc[1] - c1), 192'(512));
        while (cyc - c1 < 1023) @(negedge mclk);
        check("tx_ready_pre_boundary", 192'(tx_ready1), 192'(1));
        tx_data1 = fd[95:0]; tx_load1 = 1;
        @(negedge mclk); tx_load1 = 0;
        check("underrun_on_boundary_load", 192'(tx_underrun1), 192'(1));
        check("tx_ready_after_boundary_load", 192'(tx_ready1), 192'(0));
        wait_rx(1, 4, 1200);
        repeat (8) @(negedge mclk);
        check("underrun_count_tdm", 192'(und_cnt[1]), 192'(2));
        check("rx_queue_drained_c", 192'(exp_rx.size()), 192'(0));
        check("tx_queue_drained_c", 192'(exp_tx.size()), 192'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
